// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache (8 lines x 16 bytes) between
// the memory stage and a 128-bit block memory; misses stall through BUSY_WAIT.
module data_cache #(
  parameter int SETS       = 8,
  parameter int BLOCK_BITS = 128
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [3:0]            memRead,
  input  logic [2:0]            memWrite,
  input  logic [31:0]           ADDRESS,
  input  logic [31:0]           WRITE_DATA,
  output logic [31:0]           READ_DATA,
  output logic                  BUSY_WAIT,
  output logic                  MAIN_MEM_READ,
  output logic                  MAIN_MEM_WRITE,
  output logic [27:0]           MAIN_MEM_ADDRESS,
  output logic [BLOCK_BITS-1:0] MAIN_MEM_WRITE_DATA,
  input  logic [BLOCK_BITS-1:0] MAIN_MEM_READ_DATA,
  input  logic                  MAIN_MEM_BUSY_WAIT
);
  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = 4;
  localparam int TAG_W = 32 - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
  state_t state, state_nxt;

  logic [SETS-1:0]       valid, dirty;
  logic [TAG_W-1:0]      tag_arr  [SETS];
  logic [BLOCK_BITS-1:0] data_arr [SETS];
  logic [27:0]           miss_blk;
  logic [BLOCK_BITS-1:0] fill_buf;

  logic [IDX_W-1:0] idx, midx;
  logic             rd_act, wr_act, req, hit;
  assign idx    = ADDRESS[OFF_W +: IDX_W];
  // the miss block is latched so a dropped request still fills a consistent line
  assign midx   = miss_blk[IDX_W-1:0];
  assign wr_act = memWrite[2];
  assign rd_act = memRead[3] && !wr_act;
  assign req    = memRead[3] || wr_act;
  assign hit    = valid[idx] && (tag_arr[idx] == ADDRESS[31:32-TAG_W]);
  assign BUSY_WAIT = req && !(state == IDLE && hit);

  logic [BLOCK_BITS-1:0] line;
  logic [31:0]           word;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  assign line  = data_arr[idx];
  assign word  = line[{ADDRESS[3:2], 5'b0} +: 32];
  assign rbyte = word[{ADDRESS[1:0], 3'b0} +: 8];
  assign rhalf = word[{ADDRESS[1], 4'b0} +: 16];

  always_comb begin
    READ_DATA = '0;
    if (rd_act && hit && state == IDLE) begin
      case (memRead[2:0])
        3'b000:  READ_DATA = {{24{rbyte[7]}}, rbyte};
        3'b001:  READ_DATA = {{16{rhalf[15]}}, rhalf};
        3'b010:  READ_DATA = word;
        3'b100:  READ_DATA = {24'b0, rbyte};
        3'b101:  READ_DATA = {16'b0, rhalf};
        default: READ_DATA = '0;
      endcase
    end
  end

  // store data replicated across the word so each lane can pick its own byte
  logic [15:0]           wmask;
  logic [31:0]           wrep;
  logic [BLOCK_BITS-1:0] wblock;
  always_comb begin
    wmask = '0;
    wrep  = WRITE_DATA;
    case (memWrite[1:0])
      2'b00: begin
        wmask[ADDRESS[3:0]] = 1'b1;
        wrep = {4{WRITE_DATA[7:0]}};
      end
      2'b01: begin
        wmask[{ADDRESS[3:1], 1'b0} +: 2] = 2'b11;
        wrep = {2{WRITE_DATA[15:0]}};
      end
      2'b10:   wmask[{ADDRESS[3:2], 2'b00} +: 4] = 4'hF;
      default: ;
    endcase
    wblock = line;
    for (int b = 0; b < 16; b++)
      if (wmask[b]) wblock[8*b +: 8] = wrep[8*(b%4) +: 8];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req && !hit) state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
      WRITEBACK: if (!MAIN_MEM_BUSY_WAIT) state_nxt = FETCH;
      FETCH:     if (!MAIN_MEM_BUSY_WAIT) state_nxt = UPDATE;
      UPDATE:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign MAIN_MEM_WRITE = (state == WRITEBACK);
  assign MAIN_MEM_READ  = (state == FETCH);
  always_comb begin
    MAIN_MEM_ADDRESS    = '0;
    MAIN_MEM_WRITE_DATA = '0;
    if (state == WRITEBACK) begin
      MAIN_MEM_ADDRESS    = {tag_arr[midx], midx};
      MAIN_MEM_WRITE_DATA = data_arr[midx];
    end else if (state == FETCH) begin
      MAIN_MEM_ADDRESS    = miss_blk;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      miss_blk <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req && !hit) miss_blk <= ADDRESS[31:4];
      if (state == IDLE && wr_act && hit) dirty[idx] <= 1'b1;
      if (state == UPDATE) begin
        valid[midx] <= 1'b1;
        dirty[midx] <= 1'b0;
      end
    end
  end

  // tag and data arrays carry no reset; valid bits gate them
  always_ff @(posedge CLK) begin
    if (state == FETCH && !MAIN_MEM_BUSY_WAIT) fill_buf <= MAIN_MEM_READ_DATA;
    if (state == UPDATE) begin
      tag_arr[midx]  <= miss_blk[27:IDX_W];
      data_arr[midx] <= fill_buf;
    end else if (state == IDLE && wr_act && hit) begin
      data_arr[idx] <= wblock;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: flat block-level memory model plus a set-presence
// model predicting hits, evictions and main-memory traffic.
module tb_data_cache;
  logic         CLK = 0, RESET = 0;
  logic [3:0]   memRead = 0;
  logic [2:0]   memWrite = 0;
  logic [31:0]  ADDRESS = 0, WRITE_DATA = 0;
  logic [31:0]  READ_DATA;
  logic         BUSY_WAIT, MAIN_MEM_READ, MAIN_MEM_WRITE, MAIN_MEM_BUSY_WAIT;
  logic [27:0]  MAIN_MEM_ADDRESS;
  logic [127:0] MAIN_MEM_WRITE_DATA, MAIN_MEM_READ_DATA;

  always #5 CLK = ~CLK;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .memRead(memRead), .memWrite(memWrite),
    .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
    .BUSY_WAIT(BUSY_WAIT), .MAIN_MEM_READ(MAIN_MEM_READ), .MAIN_MEM_WRITE(MAIN_MEM_WRITE),
    .MAIN_MEM_ADDRESS(MAIN_MEM_ADDRESS), .MAIN_MEM_WRITE_DATA(MAIN_MEM_WRITE_DATA),
    .MAIN_MEM_READ_DATA(MAIN_MEM_READ_DATA), .MAIN_MEM_BUSY_WAIT(MAIN_MEM_BUSY_WAIT)
  );

  // main memory: busy for lat+1 cycles per request
  logic [127:0] mm [logic [27:0]];
  int lat = 1, mcnt = 0, both_cnt = 0;

  function automatic logic [127:0] init_blk(logic [27:0] a);
    return {4'h3, a, 4'h2, a, 4'h1, a, 4'h0, a};
  endfunction
  function automatic logic [127:0] mm_get(logic [27:0] a);
    return mm.exists(a) ? mm[a] : init_blk(a);
  endfunction

  assign MAIN_MEM_BUSY_WAIT = (MAIN_MEM_READ || MAIN_MEM_WRITE) && (mcnt != lat);

  always @(posedge CLK) begin
    if (MAIN_MEM_READ && MAIN_MEM_WRITE) both_cnt++;
    if (MAIN_MEM_READ || MAIN_MEM_WRITE) begin
      if (mcnt == lat) begin
        if (MAIN_MEM_WRITE) mm[MAIN_MEM_ADDRESS] = MAIN_MEM_WRITE_DATA;
        mcnt <= 0;
      end else mcnt <= mcnt + 1;
    end else mcnt <= 0;
  end
  always @(negedge CLK) MAIN_MEM_READ_DATA = mm_get(MAIN_MEM_ADDRESS);

  // reference: architectural block contents plus which block each set holds
  logic [127:0] ref_blk [logic [27:0]];
  logic         cval [8];
  logic         cdirty [8];
  logic [24:0]  ctag [8];

  function automatic logic [127:0] ref_get(logic [27:0] a);
    return ref_blk.exists(a) ? ref_blk[a] : mm_get(a);
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    logic [127:0] blk;
    logic [31:0]  v;
    int sz, o;
    blk = ref_get(a[31:4]);
    sz  = 1 << f3[1:0];
    o   = int'(a[3:0]);
    o   = o - (o % sz);
    v   = '0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = blk[8*(o+k) +: 8];
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 1);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [127:0] blk;
    int sz, o;
    blk = ref_get(a[31:4]);
    sz  = 1 << f3[1:0];
    o   = int'(a[3:0]);
    o   = o - (o % sz);
    for (int k = 0; k < sz; k++) blk[8*(o+k) +: 8] = wd[8*k +: 8];
    ref_blk[a[31:4]] = blk;
  endtask

  // dirty data not yet written back is lost on reset
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      if (cval[i] && cdirty[i]) ref_blk[{ctag[i], i[2:0]}] = mm_get({ctag[i], i[2:0]});
      cval[i] = 0;
      cdirty[i] = 0;
    end
  endtask

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0]  last_rd;
  logic [127:0] last_wb;
  logic [27:0]  last_wa, last_fa;
  int           last_n;

  task automatic do_op(input bit is_wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    logic [2:0]   idx;
    logic [24:0]  tg;
    logic [127:0] eblk;
    bit hit, evict, seen, stable;
    int rd_cyc, wr_cyc, upd_cyc, n;
    idx = a[6:4];
    tg  = a[31:7];
    hit   = cval[idx] && ctag[idx] == tg;
    evict = !hit && cval[idx] && cdirty[idx];
    eblk  = ref_get({ctag[idx], idx});
    seen = 0; stable = 1; rd_cyc = 0; wr_cyc = 0; upd_cyc = 0; n = 0;
    memRead    = is_wr ? 4'b0 : {1'b1, f3};
    memWrite   = is_wr ? {1'b1, f3[1:0]} : 3'b0;
    ADDRESS    = a;
    WRITE_DATA = wd;
    #1;
    chk("busy_first", BUSY_WAIT, !hit);
    while (BUSY_WAIT && n < 200) begin
      @(posedge CLK); #1; n++;
      if (MAIN_MEM_WRITE) begin
        if (wr_cyc == 0) begin last_wa = MAIN_MEM_ADDRESS; last_wb = MAIN_MEM_WRITE_DATA; end
        else if (MAIN_MEM_ADDRESS != last_wa) stable = 0;
        wr_cyc++; seen = 1;
      end else if (MAIN_MEM_READ) begin
        if (rd_cyc == 0) last_fa = MAIN_MEM_ADDRESS;
        else if (MAIN_MEM_ADDRESS != last_fa) stable = 0;
        rd_cyc++; seen = 1;
      end else if (BUSY_WAIT && seen) upd_cyc++;
    end
    last_n = n;
    chk("stall_bound", n < 200, 1);
    if (!hit) begin
      chk("wb_cycles", wr_cyc, evict ? lat + 1 : 0);
      if (evict) begin
        chk("wb_addr", last_wa, {ctag[idx], idx});
        chk("wb_data", last_wb, eblk);
      end
      chk("fetch_cycles", rd_cyc, lat + 1);
      chk("fetch_addr", last_fa, a[31:4]);
      chk("update_cycles", upd_cyc, 1);
      chk("req_stable", stable, 1);
      cval[idx] = 1; ctag[idx] = tg; cdirty[idx] = 0;
    end
    if (!is_wr) begin
      last_rd = READ_DATA;
      chk("load", READ_DATA, ref_load(f3, a));
    end else begin
      ref_store(f3, a, wd);
      cdirty[idx] = 1;
    end
    @(posedge CLK); #1;
    memRead = 0; memWrite = 0;
  endtask

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SW = 3'b010;

  initial begin
    int k;
    logic [2:0] f3;
    bit wr;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin cval[i] = 0; cdirty[i] = 0; ctag[i] = '0; end

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_mm_read", MAIN_MEM_READ, 0);
    chk("rst_mm_write", MAIN_MEM_WRITE, 0);
    chk("rst_mm_addr", MAIN_MEM_ADDRESS, 0);
    chk("rst_mm_wdata", MAIN_MEM_WRITE_DATA, 0);
    chk("rst_busy", BUSY_WAIT, 0);
    chk("rst_rdata", READ_DATA, 0);
    RESET = 1;
    @(posedge CLK); #1;

    mm[28'h1] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    lat = 2;
    do_op(0, LW, 32'h10, 0);
    chk("first_fill_val", last_rd, 32'hDEADBEEF);
    chk("first_fill_addr", last_fa, 28'h1);
    do_op(0, LW, 32'h10, 0);
    chk("hit_no_stall", last_n, 0);
    do_op(1, SW, 32'h14, 32'h12345678);
    do_op(0, LW, 32'h14, 0);  chk("sw_lw", last_rd, 32'h12345678);
    do_op(1, SB, 32'h15, 32'h555555AA);
    do_op(0, LW, 32'h14, 0);  chk("sb_lw", last_rd, 32'h1234AA78);
    do_op(0, LB, 32'h15, 0);  chk("lb", last_rd, 32'hFFFFFFAA);
    do_op(0, LBU, 32'h15, 0); chk("lbu", last_rd, 32'h000000AA);
    do_op(0, LH, 32'h14, 0);  chk("lh", last_rd, 32'hFFFFAA78);
    do_op(0, LHU, 32'h14, 0); chk("lhu", last_rd, 32'h0000AA78);
    do_op(0, LW, 32'h90, 0);
    chk("evict_addr", last_wa, 28'h1);
    chk("evict_word1", last_wb[63:32], 32'h1234AA78);
    chk("evict_fetch", last_fa, 28'h9);
    do_op(0, LW, 32'h20, 0);
    lat = 5;
    do_op(0, LW, 32'h30, 0);
    chk("slow_stall", last_n, 8);

    // reset in the middle of a fetch
    lat = 3;
    memRead = {1'b1, LW}; ADDRESS = 32'h1B0;
    k = 0;
    do begin @(posedge CLK); #1; k++; end while (!MAIN_MEM_READ && k < 20);
    chk("midfetch_seen", MAIN_MEM_READ, 1);
    RESET = 0;
    #1;
    chk("midfetch_rst_read", MAIN_MEM_READ, 0);
    chk("midfetch_rst_addr", MAIN_MEM_ADDRESS, 0);
    model_reset();
    memRead = 0;
    @(posedge CLK); #1;
    RESET = 1;
    @(posedge CLK); #1;
    do_op(0, LW, 32'h1B0, 0);
    chk("refetch_stall", last_n > 0, 1);

    for (int i = 0; i < 200; i++) begin
      lat = $urandom_range(1, 3);
      wr  = $urandom_range(0, 1);
      k   = $urandom_range(0, 4);
      f3  = wr ? 3'($urandom_range(0, 2)) : (k < 3 ? 3'(k) : 3'(k + 1));
      a   = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
      do_op(wr, f3, a, $urandom);
    end
    chk("rd_wr_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
